// File: rtl/calc_mem_pkg.sv
// Shared constants and types for the calculator working-memory arbiter.
package calc_mem_pkg;

    localparam int MEM_DATA_W = 32;
    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DEPTH  = 8;

    // Access sequencer states: grant, drive memory, present response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Index of one of the two requesters.
    typedef logic req_idx_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshake and memory-side bus of the working-memory arbiter.
interface mem_arbiter_if #(
    parameter int DATA_W = calc_mem_pkg::MEM_DATA_W,
    parameter int ADDR_W = calc_mem_pkg::MEM_ADDR_W
);

    // Requester side
    logic [1:0]        req_i;
    logic [1:0]        we_i;
    logic [ADDR_W-1:0] addr0_i;
    logic [ADDR_W-1:0] addr1_i;
    logic [DATA_W-1:0] wdata0_i;
    logic [DATA_W-1:0] wdata1_i;
    logic [1:0]        ack_o;
    logic              err_o;
    logic [DATA_W-1:0] rdata_o;

    // Memory side
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_rdata_i;

    // Arbiter view
    modport slave (
        input  req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
        output ack_o, err_o, rdata_o, mem_addr_o, mem_wdata_o, mem_we_o
    );

    // Requester / memory environment view
    modport master (
        output req_i, we_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
        input  ack_o, err_o, rdata_o, mem_addr_o, mem_wdata_o, mem_we_o
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, contention goes to the pointer.
module rr_arbiter2
    import calc_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_idx_t   ptr_i,
    output logic       valid_o,
    output req_idx_t   winner_o
);

    // Select the winner combinationally from the request vector and pointer.
    always_comb begin
        valid_o = |req_i;
        if (req_i == 2'b11) begin
            winner_o = ptr_i;
        end else begin
            winner_o = req_i[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and access sequencer for the 8 x 32-bit working memory.
// Each access takes IDLE -> ACCESS -> RESP; the memory writes mid-ACCESS on
// the falling edge, so the response captured at the end of ACCESS already
// reflects a write made by the same access.
module mem_arbiter
    import calc_mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DEPTH  = MEM_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    state_t            state_q,     state_d;
    req_idx_t          rr_ptr_q,    rr_ptr_d;
    req_idx_t          idx_q,       idx_d;
    logic              oor_q,       oor_d;
    logic [1:0]        ack_q,       ack_d;
    logic              err_q,       err_d;
    logic [DATA_W-1:0] rdata_q,     rdata_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;

    logic              win_valid;
    req_idx_t          win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              win_oor;

    rr_arbiter2 u_rr (
        .req_i    (bus.req_i),
        .ptr_i    (rr_ptr_q),
        .valid_o  (win_valid),
        .winner_o (win_idx)
    );

    // Route the winning requester's address and data, and flag out-of-range.
    always_comb begin
        win_addr  = win_idx ? bus.addr1_i  : bus.addr0_i;
        win_wdata = win_idx ? bus.wdata1_i : bus.wdata0_i;
        win_oor   = (win_addr >= ADDR_W'(DEPTH));
    end

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        // NOTE: every target gets a hold default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        oor_d       = oor_q;
        ack_d       = ack_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;

        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    idx_d       = win_idx;
                    oor_d       = win_oor;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                    mem_we_d    = bus.we_i[win_idx] & ~win_oor;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                rdata_d  = oor_q ? '0 : bus.mem_rdata_i;
                err_d    = oor_q;
                ack_d    = idx_q ? 2'b10 : 2'b01;
                mem_we_d = 1'b0;
                state_d  = RESP;
            end
            RESP: begin
                ack_d    = 2'b00;
                err_d    = 1'b0;
                rr_ptr_d = ~idx_q;
                state_d  = IDLE;
            end
            default: begin
                ack_d    = 2'b00;
                err_d    = 1'b0;
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // Sequencer registers; the async reset kills an in-flight write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            idx_q       <= 1'b0;
            oor_q       <= 1'b0;
            ack_q       <= 2'b00;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            oor_q       <= oor_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.ack_o       = ack_q;
    assign bus.err_o       = err_q;
    assign bus.rdata_o     = rdata_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.mem_we_o    = mem_we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory, a transaction-level
// reference (pending requests, last-served requester, shadow memory) and
// directed plus random access sequences.
module tb_mem_arbiter;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural working memory: write on the falling edge, combinational read.
    logic [31:0] mem [DEPTH];
    always @(negedge clk) begin
        if (bus.mem_we_o === 1'b1 && int'(bus.mem_addr_o) < DEPTH)
            mem[bus.mem_addr_o[2:0]] <= bus.mem_wdata_o;
    end
    assign bus.mem_rdata_i = (int'(bus.mem_addr_o) < DEPTH) ? mem[bus.mem_addr_o[2:0]] : 32'h0;

    // Count falling edges on which the memory sees a write strobe.
    int we_cycles = 0;
    always @(negedge clk) if (bus.mem_we_o === 1'b1) we_cycles++;

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    int          last_served = 1;  // requester 0 is favoured first
    int          exp_we      = 0;
    bit          pend   [2];
    bit          p_we   [2];
    logic [7:0]  p_addr [2];
    logic [31:0] p_data [2];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Raise a request and hold its fields until it is served.
    task automatic post(int r, bit we, logic [7:0] addr, logic [31:0] data);
        pend[r]   = 1'b1;
        p_we[r]   = we;
        p_addr[r] = addr;
        p_data[r] = data;
        bus.req_i[r] = 1'b1;
        bus.we_i[r]  = we;
        if (r == 0) begin
            bus.addr0_i  = addr;
            bus.wdata0_i = data;
        end else begin
            bus.addr1_i  = addr;
            bus.wdata1_i = data;
        end
    endtask

    // Predict the next served request, wait for its ack and compare.
    // Called just after a rising edge with the arbiter idle.
    task automatic serve(string tag);
        int          w;
        int          cyc;
        bit          seen;
        logic [1:0]  exp_ack;
        logic        exp_err;
        logic [31:0] exp_rd;
        if (pend[0] && pend[1]) w = 1 - last_served;
        else                    w = pend[1] ? 1 : 0;
        exp_ack = (w == 1) ? 2'b10 : 2'b01;
        if (int'(p_addr[w]) >= DEPTH) begin
            exp_err = 1'b1;
            exp_rd  = 32'h0;
        end else begin
            exp_err = 1'b0;
            if (p_we[w]) begin
                ref_mem[p_addr[w][2:0]] = p_data[w];
                exp_we++;
            end
            exp_rd = ref_mem[p_addr[w][2:0]];
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 10) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (bus.ack_o !== 2'b00) seen = 1'b1;
        end
        check({tag, ".latency"}, 64'(cyc), 64'd2);
        check({tag, ".ack"},     64'(bus.ack_o),   64'(exp_ack));
        check({tag, ".err"},     64'(bus.err_o),   64'(exp_err));
        check({tag, ".rdata"},   64'(bus.rdata_o), 64'(exp_rd));
        @(posedge clk);
        #1;
        check({tag, ".ack_drop"},   64'({bus.err_o, bus.ack_o}), 64'd0);
        check({tag, ".rdata_hold"}, 64'(bus.rdata_o), 64'(exp_rd));
        pend[w]      = 1'b0;
        bus.req_i[w] = 1'b0;
        last_served  = w;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        bit idle_bad;
        bus.req_i    = 2'b00;
        bus.we_i     = 2'b00;
        bus.addr0_i  = '0;
        bus.addr1_i  = '0;
        bus.wdata0_i = '0;
        bus.wdata1_i = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 32'h11 * i;
            ref_mem[i] = 32'h11 * i;
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;

        // Reset values
        #1;
        check("reset.ack",       64'(bus.ack_o),       64'd0);
        check("reset.err",       64'(bus.err_o),       64'd0);
        check("reset.rdata",     64'(bus.rdata_o),     64'd0);
        check("reset.mem_addr",  64'(bus.mem_addr_o),  64'd0);
        check("reset.mem_wdata", 64'(bus.mem_wdata_o), 64'd0);
        check("reset.mem_we",    64'(bus.mem_we_o),    64'd0);
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention from reset: requester 0 first, then requester 1
        post(0, 1'b0, 8'd1, 32'h0);
        post(1, 1'b0, 8'd2, 32'h0);
        serve("cont0");
        serve("cont1");

        // Single write then read-back
        post(0, 1'b1, 8'd3, 32'hDEADBEEF);
        serve("wr3");
        post(0, 1'b0, 8'd3, 32'h0);
        serve("rd3");

        // Sustained contention: req0 writes addr 6, req1 reads it
        for (int i = 0; i < 6; i++) begin
            if (!pend[0]) post(0, 1'b1, 8'd6, 32'hA000_0000 + 32'(i));
            if (!pend[1]) post(1, 1'b0, 8'd6, 32'h0);
            serve("sustain");
        end
        if (pend[0]) serve("sustain_tail");
        if (pend[1]) serve("sustain_tail");

        // Out-of-range write must not strobe the memory
        w0 = we_cycles;
        post(1, 1'b1, 8'd8, 32'h12345678);
        serve("oor_wr");
        check("oor.no_we", 64'(we_cycles), 64'(w0));
        post(0, 1'b0, 8'd0, 32'h0);
        serve("rd0");

        // Idle: no strobes and no acks for 20 cycles
        idle_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_we_o !== 1'b0 || bus.ack_o !== 2'b00) idle_bad = 1'b1;
        end
        check("idle.quiet", 64'(idle_bad), 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back from a held request: next ack three cycles later
        post(0, 1'b0, 8'd2, 32'h0);
        serve("b2b_a");
        post(0, 1'b0, 8'd2, 32'h0);
        serve("b2b_b");

        // Reset in the middle of a write aborts it
        post(0, 1'b1, 8'd5, 32'hCAFEF00D);
        @(posedge clk);
        #1;
        check("abort.we_live", 64'(bus.mem_we_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort.mem_we",   64'(bus.mem_we_o),    64'd0);
        check("abort.mem_addr", 64'(bus.mem_addr_o),  64'd0);
        check("abort.rdata",    64'(bus.rdata_o),     64'd0);
        check("abort.ack",      64'({bus.err_o, bus.ack_o}), 64'd0);
        @(negedge clk);
        bus.req_i = 2'b00;
        pend[0]   = 1'b0;
        last_served = 1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        post(1, 1'b0, 8'd5, 32'h0);
        post(0, 1'b0, 8'd7, 32'h0);
        serve("post_rst_a");
        serve("post_rst_b");

        // Random traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1)
                    post(r, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 10)), $urandom);
            end
            if (!pend[0] && !pend[1])
                post(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 10)), $urandom);
            serve("rand");
        end
        while (pend[0] || pend[1]) serve("rand_tail");

        check("we_strobe_count", 64'(we_cycles), 64'(exp_we));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
